// File: rtl/development_stage_tracker.sv
// Level-to-stage tracker: saturating level integrator with dwell-qualified stage advance and hysteretic regression.
// Optional idle decay of the level is enabled by defining DEV_STAGE_DECAY_EN.
module development_stage_tracker #(
  parameter int N            = 9,
  parameter int STAGE_W      = 2,
  parameter int FAST_STEP    = 2,
  parameter int SET_VAL      = 0,
  parameter int DEFAULT_VAL  = 0,
  parameter int DWELL        = 4,
  parameter int HYST         = 8,
  parameter int MONOTONIC    = 0,
  parameter int DECAY_PERIOD = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  input  logic               fast,
  input  logic               setval,
  output logic [N-1:0]       level,
  output logic [STAGE_W-1:0] stage,
  output logic               stage_changed,
  output logic               stage_max
);

  localparam int BAND_SH = N - STAGE_W;
  localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef logic [N:0] wide_t;
  localparam wide_t LEVEL_MAX = wide_t'((1 << N) - 1);

  if (DWELL < 1) begin : g_bad_dwell
    $error("DWELL must be at least 1");
  end
  if (DECAY_PERIOD < 1) begin : g_bad_decay
    $error("DECAY_PERIOD must be at least 1");
  end

  logic [N-1:0]       level_q, level_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               changed_q;
  logic               decay_hit;

`ifdef DEV_STAGE_DECAY_EN
  localparam int DECAY_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  logic [DECAY_W-1:0] decay_cnt_q, decay_cnt_d;

  // Any request restarts the idle window; only fully idle cycles count towards decay.
  always_comb begin
    decay_cnt_d = '0;
    decay_hit   = 1'b0;
    if (!(inc || dec || setval)) begin
      if (decay_cnt_q == DECAY_W'(DECAY_PERIOD - 1)) decay_hit = 1'b1;
      else decay_cnt_d = decay_cnt_q + DECAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) decay_cnt_q <= '0;
    else     decay_cnt_q <= decay_cnt_d;
  end
`else
  assign decay_hit = 1'b0;
`endif

  wide_t step, level_w, sum;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    step    = fast ? wide_t'(FAST_STEP) : wide_t'(1);
    level_w = {1'b0, level_q};
    sum     = level_w + step;
    level_d = level_q;
    if (setval) begin
      level_d = N'(SET_VAL);
    end else if (inc && !dec) begin
      level_d = (sum > LEVEL_MAX) ? LEVEL_MAX[N-1:0] : sum[N-1:0];
    end else if (dec && !inc) begin
      level_d = (level_w < step) ? '0 : N'(level_w - step);
    end else if (decay_hit && level_q != '0) begin
      level_d = level_q - N'(1);
    end
  end

  logic [STAGE_W-1:0] raw;
  wide_t              floor_w, lvl_hyst;

  assign raw = level_q[N-1 -: STAGE_W];

  // Advance needs raw ahead of stage for DWELL consecutive cycles; regression is immediate once below the hysteresis margin.
  always_comb begin
    stage_d     = stage_q;
    dwell_cnt_d = '0;
    floor_w     = wide_t'(stage_q) << BAND_SH;
    lvl_hyst    = {1'b0, level_q} + wide_t'(HYST);
    if (raw > stage_q) begin
      if (dwell_cnt_q == DWELL_W'(DWELL - 1)) stage_d = stage_q + STAGE_W'(1);
      else dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
    end else if (MONOTONIC == 0 && stage_q != '0 && lvl_hyst < floor_w) begin
      stage_d = stage_q - STAGE_W'(1);
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= N'(DEFAULT_VAL);
      stage_q     <= '0;
      dwell_cnt_q <= '0;
      changed_q   <= 1'b0;
    end else begin
      level_q     <= level_d;
      stage_q     <= stage_d;
      dwell_cnt_q <= dwell_cnt_d;
      changed_q   <= (stage_d != stage_q);
    end
  end

  assign level         = level_q;
  assign stage         = stage_q;
  assign stage_changed = changed_q;
  assign stage_max     = &stage_q;

endmodule

// File: tb/tb_development_stage_tracker.sv
// Randomised and directed bench for development_stage_tracker: three instances (default, monotonic with SET_VAL=400,
// short decay period) are compared each cycle against an arithmetic reference model.
module tb_development_stage_tracker;

  localparam int N       = 9;
  localparam int STAGE_W = 2;
  localparam int BAND    = 1 << (N - STAGE_W);
  localparam int LMAX    = (1 << N) - 1;
  localparam int DWELL   = 4;
  localparam int HYST    = 8;
  localparam int OW      = N + STAGE_W + 2;
`ifdef DEV_STAGE_DECAY_EN
  localparam bit DECAY_ON = 1'b1;
`else
  localparam bit DECAY_ON = 1'b0;
`endif

  typedef struct {
    int level;
    int stage;
    int dwell;
    int decay;
    bit changed;
  } mdl_t;

  logic clk = 1'b0;
  logic rst = 1'b1, inc = 1'b0, dec = 1'b0, fast = 1'b0, setval = 1'b0;

  logic [N-1:0]       lvl [3];
  logic [STAGE_W-1:0] stg [3];
  logic               chg [3];
  logic               smax[3];
  logic [OW-1:0]      obs [3];

  int set_cfg [3] = '{0, 400, 0};
  bit mono_cfg[3] = '{1'b0, 1'b1, 1'b0};
  int per_cfg [3] = '{64, 64, 4};
  mdl_t m[3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  development_stage_tracker dut (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .level(lvl[0]), .stage(stg[0]), .stage_changed(chg[0]), .stage_max(smax[0])
  );

  development_stage_tracker #(.MONOTONIC(1), .SET_VAL(400)) dut_mono (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .level(lvl[1]), .stage(stg[1]), .stage_changed(chg[1]), .stage_max(smax[1])
  );

  development_stage_tracker #(.DECAY_PERIOD(4)) dut_dec (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .fast(fast), .setval(setval),
    .level(lvl[2]), .stage(stg[2]), .stage_changed(chg[2]), .stage_max(smax[2])
  );

  assign obs[0] = {lvl[0], stg[0], chg[0], smax[0]};
  assign obs[1] = {lvl[1], stg[1], chg[1], smax[1]};
  assign obs[2] = {lvl[2], stg[2], chg[2], smax[2]};

  // Reference: stage from integer band index level/BAND, level from clamped integer arithmetic.
  function automatic mdl_t model_next(mdl_t s, bit r, bit i, bit d, bit f, bit sv, int setv, bit mon, int per);
    mdl_t n;
    int st;
    n = s;
    st = f ? 2 : 1;
    if (r) begin
      n.level = 0; n.stage = 0; n.dwell = 0; n.decay = 0; n.changed = 1'b0;
      return n;
    end
    if (s.level / BAND > s.stage) begin
      if (s.dwell == DWELL - 1) begin n.stage = s.stage + 1; n.dwell = 0; end
      else n.dwell = s.dwell + 1;
    end else begin
      n.dwell = 0;
      if (!mon && s.stage > 0 && s.level + HYST < s.stage * BAND) n.stage = s.stage - 1;
    end
    n.changed = (n.stage != s.stage);
    n.decay = 0;
    if (sv) n.level = setv;
    else if (i && !d) n.level = (s.level + st > LMAX) ? LMAX : s.level + st;
    else if (d && !i) n.level = (s.level - st < 0) ? 0 : s.level - st;
    else if (!i && !d && DECAY_ON) begin
      if (s.decay == per - 1) n.level = (s.level > 0) ? s.level - 1 : 0;
      else n.decay = s.decay + 1;
    end
    return n;
  endfunction

  function automatic logic [OW-1:0] pack(mdl_t s);
    return {N'(s.level), STAGE_W'(s.stage), s.changed, s.stage == (1 << STAGE_W) - 1};
  endfunction

  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      m[k] <= model_next(m[k], rst, inc, dec, fast, setval, set_cfg[k], mono_cfg[k], per_cfg[k]);

  task automatic tick(input bit r, input bit i, input bit d, input bit f, input bit s);
    rst = r; inc = i; dec = d; fast = f; setval = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 1, 1);
    for (int c = 0; c < 10; c++) begin
      tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (lvl[0] !== 0 || stg[0] !== 0 || chg[0] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle c%0d: level=%0d stage=%0d chg=%b, expected 0/0/0", c, lvl[0], stg[0], chg[0]);
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== pack(m[k])) begin
          n_err++;
          $display("FAIL reset_model inst%0d: got %h expected %h", k, obs[k], pack(m[k]));
        end
      end
    end
  endtask

  task automatic test_advance();
    int first_k = -1;
    int pulses = 0;
    for (int c = 0; c < 128; c++) begin
      tick(0, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== pack(m[k])) begin
          n_err++;
          $display("FAIL advance_model inst%0d: got %h expected %h", k, obs[k], pack(m[k]));
        end
      end
    end
    n_cmp++;
    if (lvl[0] !== 9'd128) begin
      n_err++;
      $display("FAIL advance_level: got %0d expected 128", lvl[0]);
    end
    for (int c = 1; c <= 8; c++) begin
      tick(0, 0, 0, 0, 0);
      if (chg[0] === 1'b1) pulses++;
      if (stg[0] === 2'd1 && first_k < 0) first_k = c;
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== pack(m[k])) begin
          n_err++;
          $display("FAIL advance_model inst%0d: got %h expected %h", k, obs[k], pack(m[k]));
        end
      end
    end
    n_cmp++;
    if (first_k !== 4 || pulses !== 1) begin
      n_err++;
      $display("FAIL advance_timing: stage1 after %0d cycles, %0d pulses; expected 4 cycles, 1 pulse", first_k, pulses);
    end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 200; c++) tick(0, 1, 0, 1, 0);
    n_cmp++;
    if (lvl[0] !== 9'd511 || stg[0] !== 2'd3 || smax[0] !== 1'b1) begin
      n_err++;
      $display("FAIL sat_fill: level=%0d stage=%0d max=%b expected 511/3/1", lvl[0], stg[0], smax[0]);
    end
    tick(0, 1, 0, 1, 0);
    n_cmp++;
    if (lvl[0] !== 9'd511) begin
      n_err++;
      $display("FAIL sat_fast_inc: got %0d expected 511", lvl[0]);
    end
    tick(0, 1, 1, 0, 0);
    n_cmp++;
    if (lvl[0] !== 9'd511) begin
      n_err++;
      $display("FAIL sat_inc_dec_hold: got %0d expected 511", lvl[0]);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs[k] !== pack(m[k])) begin
        n_err++;
        $display("FAIL sat_model inst%0d: got %h expected %h", k, obs[k], pack(m[k]));
      end
    end
  endtask

  task automatic test_regression();
    tick(1, 0, 0, 0, 0);
    for (int c = 0; c < 128; c++) tick(0, 1, 0, 0, 0);
    for (int c = 0; c < 4; c++) tick(0, 0, 0, 0, 0);
    for (int c = 0; c < 7; c++) tick(0, 0, 1, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick(0, 0, 0, 0, 0);
      n_cmp++;
      if (lvl[0] !== 9'd121 || stg[0] !== 2'd1) begin
        n_err++;
        $display("FAIL regress_hold: level=%0d stage=%0d expected 121/1", lvl[0], stg[0]);
      end
    end
    tick(0, 0, 1, 0, 0);
    tick(0, 0, 1, 0, 0);
    n_cmp++;
    if (lvl[0] !== 9'd119 || stg[0] !== 2'd1) begin
      n_err++;
      $display("FAIL regress_pre: level=%0d stage=%0d expected 119/1", lvl[0], stg[0]);
    end
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (stg[0] !== 2'd0 || chg[0] !== 1'b1 || stg[1] !== 2'd1 || chg[1] !== 1'b0) begin
      n_err++;
      $display("FAIL regress_drop: stage=%0d chg=%b mono_stage=%0d mono_chg=%b expected 0/1/1/0",
               stg[0], chg[0], stg[1], chg[1]);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs[k] !== pack(m[k])) begin
        n_err++;
        $display("FAIL regress_model inst%0d: got %h expected %h", k, obs[k], pack(m[k]));
      end
    end
  endtask

  task automatic test_setval();
    int pulse_at[$];
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1);
    n_cmp++;
    if (lvl[1] !== 9'd400 || lvl[0] !== 9'd0) begin
      n_err++;
      $display("FAIL setval_load: mono_level=%0d level=%0d expected 400/0", lvl[1], lvl[0]);
    end
    for (int c = 1; c <= 14; c++) begin
      tick(0, 0, 0, 0, 0);
      if (chg[1] === 1'b1) pulse_at.push_back(c);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== pack(m[k])) begin
          n_err++;
          $display("FAIL setval_model inst%0d: got %h expected %h", k, obs[k], pack(m[k]));
        end
      end
    end
    n_cmp++;
    if (pulse_at.size() != 3 || pulse_at[0] != 4 || pulse_at[1] != 8 || pulse_at[2] != 12 ||
        stg[1] !== 2'd3 || smax[1] !== 1'b1) begin
      n_err++;
      $display("FAIL setval_climb: %0d pulses, stage=%0d max=%b; expected pulses at 4,8,12, stage 3, max 1",
               pulse_at.size(), stg[1], smax[1]);
    end
  endtask

  task automatic test_decay();
    tick(1, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) tick(0, 1, 0, 0, 0);
    for (int c = 0; c < 12; c++) tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (lvl[2] !== 9'(DECAY_ON ? 2 : 5)) begin
      n_err++;
      $display("FAIL decay_idle12: got %0d expected %0d", lvl[2], DECAY_ON ? 2 : 5);
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (lvl[2] !== 9'(DECAY_ON ? 3 : 6)) begin
      n_err++;
      $display("FAIL decay_restart: got %0d expected %0d", lvl[2], DECAY_ON ? 3 : 6);
    end
    tick(0, 0, 0, 0, 0);
    n_cmp++;
    if (lvl[2] !== 9'(DECAY_ON ? 2 : 6)) begin
      n_err++;
      $display("FAIL decay_after_restart: got %0d expected %0d", lvl[2], DECAY_ON ? 2 : 6);
    end
  endtask

  task automatic test_random();
    int ph, p_inc, p_dec;
    for (int c = 0; c < 3000; c++) begin
      ph = (c / 150) % 4;
      p_inc = (ph == 0) ? 60 : (ph == 1) ? 10 : (ph == 2) ? 3 : 35;
      p_dec = (ph == 1) ? 60 : (ph == 0) ? 10 : (ph == 2) ? 3 : 35;
      tick($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < p_inc,
           $urandom_range(0, 99) < p_dec,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 79) == 0);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== pack(m[k])) begin
          n_err++;
          $display("FAIL random_model c%0d inst%0d: got %h expected %h", c, k, obs[k], pack(m[k]));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_advance();
    test_saturation();
    test_regression();
    test_setval();
    test_decay();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
